// File: rtl/tile_raster_sequencer.sv
// Tile buffer owner that clears, sweeps triangles through tile_painter and drains final colors row-major.
// Define TILE_SEQ_STATS_EN to add the stat_tris / stat_cycles outputs.
module tile_raster_sequencer #(
  parameter int          TILE_W   = 16,
  parameter int          TILE_H   = 8,
  parameter logic [15:0] BG_COLOR = 16'h0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [8:0]   tile_x_in,
  input  logic [7:0]   tile_y_in,
  input  logic         tile_start,
  input  logic [127:0] tri_in,
  input  logic         tri_valid,
  input  logic         tri_last,
  output logic         tri_ready,
  output logic [8:0]   paint_x,
  output logic [7:0]   paint_y,
  output logic [31:0]  paint_pixel,
  output logic [127:0] paint_tri,
  output logic         paint_valid,
  input  logic [8:0]   painted_x,
  input  logic [7:0]   painted_y,
  input  logic [31:0]  painted_pixel,
  input  logic         painted_valid,
  output logic [8:0]   out_x,
  output logic [7:0]   out_y,
  output logic [15:0]  out_color,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         busy
`ifdef TILE_SEQ_STATS_EN
  ,
  output logic [15:0]  stat_tris,
  output logic [31:0]  stat_cycles
`endif
);

  localparam int N  = TILE_W * TILE_H;
  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, WAIT_TRI, SWEEP, FLUSH, DRAIN} state_t;

  state_t        state;
  logic [31:0]   mem [N];
  logic [31:0]   rd_data;
  logic [8:0]    tile_x;
  logic [7:0]    tile_y;
  logic [AW-1:0] cnt;
  logic          last_tri;
  logic          flush_cnt;

  logic          rd_more;
  logic          pend;
  logic [AW-1:0] pend_k;
  logic          skid_valid;
  logic [8:0]    skid_x;
  logic [7:0]    skid_y;
  logic [15:0]   skid_color;
  logic          skid_last;

  logic          draining;
  logic          pop;
  logic          issue;
  logic [1:0]    occ;
  logic [8:0]    arr_x;
  logic [7:0]    arr_y;
  logic [15:0]   arr_color;
  logic          arr_last;

  logic [8:0]    wb_dx;
  logic [7:0]    wb_dy;
  logic [AW-1:0] wb_addr;
  logic          wb_en;
  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [31:0]   mem_wd;

  function automatic logic [8:0] col_of(input logic [AW-1:0] k);
    return 9'(32'(k) % TILE_W);
  endfunction

  function automatic logic [7:0] row_of(input logic [AW-1:0] k);
    return 8'(32'(k) / TILE_W);
  endfunction

  assign paint_pixel = rd_data;

  // Painter results still in flight after a sweep land during the following WAIT_TRI or FLUSH.
  assign wb_dx   = painted_x - tile_x;
  assign wb_dy   = painted_y - tile_y;
  assign wb_addr = AW'(wb_dy) * AW'(TILE_W) + AW'(wb_dx);
  assign wb_en   = rst & painted_valid &
                   ((state == WAIT_TRI) || (state == SWEEP) || (state == FLUSH));

  assign mem_we = (rst && state == CLEAR) || wb_en;
  assign mem_wa = (state == CLEAR) ? cnt : wb_addr;
  assign mem_wd = (state == CLEAR) ? {BG_COLOR, 16'hFFFF} : painted_pixel;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // Drain reads start in FLUSH; N >= 4 keeps them clear of the two pending writebacks.
  always_comb begin
    draining  = (state == FLUSH) || (state == DRAIN);
    pop       = out_valid & out_ready;
    occ       = 2'(out_valid) + 2'(skid_valid) + 2'(pend) - 2'(pop);
    issue     = draining & rd_more & (occ <= 2'd1);
    arr_x     = tile_x + col_of(pend_k);
    arr_y     = tile_y + row_of(pend_k);
    arr_color = rd_data[31:16];
    arr_last  = (pend_k == LAST_ADDR);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      tri_ready   <= 1'b0;
      paint_valid <= 1'b0;
      paint_x     <= '0;
      paint_y     <= '0;
      paint_tri   <= '0;
      rd_data     <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_x       <= '0;
      out_y       <= '0;
      out_color   <= '0;
      tile_x      <= '0;
      tile_y      <= '0;
      cnt         <= '0;
      last_tri    <= 1'b0;
      flush_cnt   <= 1'b0;
      rd_more     <= 1'b0;
      pend        <= 1'b0;
      pend_k      <= '0;
      skid_valid  <= 1'b0;
      skid_x      <= '0;
      skid_y      <= '0;
      skid_color  <= '0;
      skid_last   <= 1'b0;
    end else begin
      paint_valid <= (state == SWEEP);
      if (state == SWEEP || issue) rd_data <= mem[cnt];

      case (state)
        IDLE: begin
          if (tile_start) begin
            tile_x <= tile_x_in;
            tile_y <= tile_y_in;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= CLEAR;
          end
        end
        CLEAR: begin
          cnt <= cnt + AW'(1);
          if (cnt == LAST_ADDR) begin
            tri_ready <= 1'b1;
            state     <= WAIT_TRI;
          end
        end
        WAIT_TRI: begin
          if (tri_valid && tri_ready) begin
            paint_tri <= tri_in;
            last_tri  <= tri_last;
            tri_ready <= 1'b0;
            state     <= SWEEP;
          end
        end
        SWEEP: begin
          paint_x <= tile_x + col_of(cnt);
          paint_y <= tile_y + row_of(cnt);
          cnt     <= cnt + AW'(1);
          if (cnt == LAST_ADDR) begin
            if (last_tri) begin
              flush_cnt <= 1'b0;
              rd_more   <= 1'b1;
              state     <= FLUSH;
            end else begin
              tri_ready <= 1'b1;
              state     <= WAIT_TRI;
            end
          end
        end
        FLUSH: begin
          flush_cnt <= 1'b1;
          if (flush_cnt) state <= DRAIN;
        end
        DRAIN: begin
          if (pop && out_last) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Output register backed by a one-entry skid; reads are issued only when both can absorb them.
      if (draining) begin
        pend <= issue;
        if (issue) begin
          pend_k <= cnt;
          cnt    <= cnt + AW'(1);
          if (cnt == LAST_ADDR) rd_more <= 1'b0;
        end
        if (pop || !out_valid) begin
          if (skid_valid) begin
            out_x      <= skid_x;
            out_y      <= skid_y;
            out_color  <= skid_color;
            out_last   <= skid_last;
            out_valid  <= 1'b1;
            skid_valid <= pend;
            if (pend) begin
              skid_x     <= arr_x;
              skid_y     <= arr_y;
              skid_color <= arr_color;
              skid_last  <= arr_last;
            end
          end else if (pend) begin
            out_x     <= arr_x;
            out_y     <= arr_y;
            out_color <= arr_color;
            out_last  <= arr_last;
            out_valid <= 1'b1;
          end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
        end else if (pend) begin
          skid_x     <= arr_x;
          skid_y     <= arr_y;
          skid_color <= arr_color;
          skid_last  <= arr_last;
          skid_valid <= 1'b1;
        end
      end
    end
  end

`ifdef TILE_SEQ_STATS_EN
  // Counters run from the first CLEAR cycle through the out_last handshake, then hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_tris   <= '0;
      stat_cycles <= '0;
    end else if (state == IDLE) begin
      if (tile_start) begin
        stat_tris   <= '0;
        stat_cycles <= '0;
      end
    end else begin
      stat_cycles <= stat_cycles + 32'd1;
      if (state == WAIT_TRI && tri_valid && tri_ready) stat_tris <= stat_tris + 16'd1;
    end
  end
`endif

endmodule
